// File: rtl/vga_port_arbiter.sv
// Two-client VGA write-port arbiter: round-robin grants with a hold timeout and an
// optional full-screen black clear engine, compiled in when VGA_ARB_CLEAR_EN is defined.
module vga_port_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int MAX_HOLD = 255
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic [7:0] c0_x,
    input  logic [7:0] c1_x,
    input  logic [6:0] c0_y,
    input  logic [6:0] c1_y,
    input  logic [2:0] c0_colour,
    input  logic [2:0] c1_colour,
    input  logic       c0_writeEn,
    input  logic       c1_writeEn,
    input  logic       clear_req,
    output logic [1:0] grant,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       clear_done,
    output logic       timeout
);
    localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    localparam int YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
`ifdef VGA_ARB_CLEAR_EN
        ,
        CLEAR
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;      // client served most recently
    logic [HW-1:0]   hold_q, hold_d;
    logic            timeout_q, timeout_d;
    logic            cur_i;

`ifdef VGA_ARB_CLEAR_EN
    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);
    logic            pend_q, pend_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            cdone_q, cdone_d;
`else
    // clear_req and the sweep geometry have no consumer in this build
    logic [XW+YW:0]  unused_clear_req;
    assign unused_clear_req = {{(XW + YW){1'b0}}, clear_req};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= '0;
            timeout_q <= 1'b0;
`ifdef VGA_ARB_CLEAR_EN
            pend_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            cdone_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`ifdef VGA_ARB_CLEAR_EN
            pend_q    <= pend_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cdone_q   <= cdone_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        cur_i     = 1'b0;
        grant     = 2'b00;
        x_out     = '0;
        y_out     = '0;
        colour    = '0;
        writeEn   = 1'b0;
`ifdef VGA_ARB_CLEAR_EN
        pend_d    = pend_q;
        x_d       = x_q;
        y_d       = y_q;
        cdone_d   = 1'b0;
        if (clear_req && state_q != CLEAR) pend_d = 1'b1;
`endif
        case (state_q)
            IDLE: begin
                hold_d = HW'(1);
`ifdef VGA_ARB_CLEAR_EN
                if (pend_q) begin
                    state_d = CLEAR;
                    pend_d  = 1'b0;
                end else
`endif
                if (req == 2'b11) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                    last_d  = ~last_q;
                end else if (req[0]) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (req[1]) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                cur_i   = (state_q == GRANT1);
                grant   = cur_i ? 2'b10 : 2'b01;
                x_out   = cur_i ? c1_x : c0_x;
                y_out   = cur_i ? c1_y : c0_y;
                colour  = cur_i ? c1_colour : c0_colour;
                writeEn = cur_i ? c1_writeEn : c0_writeEn;
                if (done[cur_i] || !req[cur_i]) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
`ifdef VGA_ARB_CLEAR_EN
            CLEAR: begin
                x_out   = 8'(x_q);
                y_out   = 7'(y_q);
                writeEn = 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = IDLE;
                        cdone_d = 1'b1;
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign timeout = timeout_q;
`ifdef VGA_ARB_CLEAR_EN
    assign clear_done = cdone_q;
`else
    assign clear_done = 1'b0;
`endif

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Scoreboard bench for vga_port_arbiter: expected grants are queued as stimulus is driven
// and checked by a monitor as grants start and end; clear tests follow VGA_ARB_CLEAR_EN.
module tb_vga_port_arbiter;
    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] req, done;
    logic [7:0] c0_x, c1_x;
    logic [6:0] c0_y, c1_y;
    logic [2:0] c0_colour, c1_colour;
    logic       c0_writeEn, c1_writeEn, clear_req;
    logic [1:0] grant;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       writeEn, clear_done, timeout;

    vga_port_arbiter dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .c0_x(c0_x), .c1_x(c1_x), .c0_y(c0_y), .c1_y(c1_y),
        .c0_colour(c0_colour), .c1_colour(c1_colour),
        .c0_writeEn(c0_writeEn), .c1_writeEn(c1_writeEn), .clear_req(clear_req),
        .grant(grant), .x_out(x_out), .y_out(y_out), .colour(colour),
        .writeEn(writeEn), .clear_done(clear_done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] g;
        int         len;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Grant monitor: pops an expectation when a grant starts, checks its length and timeout when it ends.
    logic [1:0] prev_g = 2'b00;
    int         g_len = 0;
    always @(negedge clk) begin
        if (grant != 2'b00 && prev_g == 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", {30'd0, grant}, 0);
                cur = '{g: grant, len: -1, to: 1'b0};
            end else begin
                cur = exp_q.pop_front();
                chk("grant_val", {30'd0, grant}, {30'd0, cur.g});
            end
            g_len = 1;
        end else if (grant != 2'b00) begin
            if (grant != prev_g) chk("back_to_back", {30'd0, grant}, {30'd0, prev_g});
            g_len++;
        end else if (prev_g != 2'b00 && cur.len >= 0) begin
            chk("hold_len", g_len, cur.len);
            chk("timeout_at_end", {31'd0, timeout}, {31'd0, cur.to});
        end
        prev_g = grant;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = 2'b00; done = 2'b00; clear_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 10; i++) begin
            if (grant != 2'b00) return;
            @(negedge clk);
        end
        if (grant == 2'b00) chk("wait_grant_expired", 0, 1);
    endtask

    // Ends the current grant with done in its len-th cycle; optionally drops all requests too.
    task automatic run_burst(input int len, input logic [7:0] exp_x, input bit drop);
        logic [1:0] g;
        wait_grant();
        chk("mux_x", {24'd0, x_out}, {24'd0, exp_x});
        for (int i = 1; i < len; i++) tick();
        g = grant;
        done = g;
        if (drop) req = 2'b00;
        tick();
        done = 2'b00;
    endtask

    initial begin
        c0_x = 8'd37; c0_y = 7'd100; c0_colour = 3'd5; c0_writeEn = 1'b1;
        c1_x = 8'd200; c1_y = 7'd3; c1_colour = 3'd2; c1_writeEn = 1'b0;

        // single client burst, idle outputs held at zero while client data is live
        do_reset();
        @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 0);
        chk("rst_we", {31'd0, writeEn}, 0);
        chk("rst_xyc", {14'd0, x_out, y_out, colour}, 0);
        chk("rst_flags", {30'd0, timeout, clear_done}, 0);
        tick();
        req = 2'b01;
        exp_q.push_back('{g: 2'b01, len: 30, to: 1'b0});
        @(negedge clk);
        chk("lat_idle", {30'd0, grant}, 0);
        tick();
        chk("lat_grant", {30'd0, grant}, 1);
        chk("c0_x", {24'd0, x_out}, 37);
        chk("c0_y", {25'd0, y_out}, 100);
        chk("c0_colour", {29'd0, colour}, 5);
        chk("c0_we", {31'd0, writeEn}, 1);
        c0_x = 8'd12;
        #1 chk("c0_x_follow", {24'd0, x_out}, 12);
        repeat (29) tick();
        done = 2'b01; req = 2'b00;
        tick();
        done = 2'b00;
        chk("post_idle_grant", {30'd0, grant}, 0);
        chk("post_idle_we", {31'd0, writeEn}, 0);

        // round robin with both clients requesting
        do_reset();
        req = 2'b11;
        exp_q.push_back('{g: 2'b01, len: 5, to: 1'b0});
        exp_q.push_back('{g: 2'b10, len: 5, to: 1'b0});
        exp_q.push_back('{g: 2'b01, len: 5, to: 1'b0});
        run_burst(5, 8'd12, 1'b0);
        chk("gap_after_g0", {30'd0, grant}, 0);
        run_burst(5, 8'd200, 1'b0);
        chk("gap_after_g1", {30'd0, grant}, 0);
        run_burst(5, 8'd12, 1'b1);

        // hold timeout, then the waiting client is served
        do_reset();
        req = 2'b11;
        exp_q.push_back('{g: 2'b01, len: 255, to: 1'b1});
        exp_q.push_back('{g: 2'b10, len: 3, to: 1'b0});
        wait_grant();
        begin
            int i;
            for (i = 0; i < 300; i++) begin
                @(negedge clk);
                if (grant == 2'b00) break;
            end
            if (i == 300) chk("wait_drop_expired", 0, 1);
        end
        chk("timeout_pulse", {31'd0, timeout}, 1);
        @(negedge clk);
        chk("timeout_one_cycle", {31'd0, timeout}, 0);
        run_burst(3, 8'd200, 1'b1);

`ifdef VGA_ARB_CLEAR_EN
        // clear requested mid-grant: grant completes, then full sweep
        do_reset();
        req = 2'b01;
        exp_q.push_back('{g: 2'b01, len: 10, to: 1'b0});
        wait_grant();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (8) tick();
        done = 2'b01; req = 2'b00;
        tick();
        done = 2'b00;
        @(negedge clk);
        chk("pre_clear_idle", {31'd0, writeEn}, 0);
        begin
            int n, errs, ex, ey, lx, ly;
            n = 0; errs = 0; ex = 0; ey = 0; lx = -1; ly = -1;
            for (int i = 0; i < 20000; i++) begin
                @(negedge clk);
                if (!writeEn) break;
                if (x_out != ex[7:0] || y_out != ey[6:0] || colour != 3'd0 || grant != 2'b00) errs++;
                lx = x_out; ly = y_out;
                n++;
                if (ex == 159) begin ex = 0; ey++; end else ex++;
                if (n == 100) clear_req = 1'b1;
                if (n == 101) clear_req = 1'b0;
            end
            chk("clr_pixel_errs", errs, 0);
            chk("clr_cycles", n, 19200);
            chk("clr_last_x", lx, 159);
            chk("clr_last_y", ly, 119);
            chk("clr_done_pulse", {31'd0, clear_done}, 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clr_absorbed", {30'd0, writeEn, clear_done}, 0);
        end

        // reset during the sweep aborts it; the next sweep restarts at the origin
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (writeEn) break;
        end
        chk("clr2_first", {16'd0, x_out, 1'b0, y_out}, 0);
        repeat (5000) @(negedge clk);
        chk("clr2_px5000_x", {24'd0, x_out}, 40);
        chk("clr2_px5000_y", {25'd0, y_out}, 31);
        resetn = 1'b0;
        #1;
        chk("abort_outputs", {14'd0, writeEn, x_out, y_out}, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        begin
            logic cd;
            cd = 1'b0;
            repeat (25) begin
                @(negedge clk);
                cd = cd | clear_done | writeEn;
            end
            chk("abort_no_done", {31'd0, cd}, 0);
        end
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (writeEn) break;
        end
        chk("clr3_we", {31'd0, writeEn}, 1);
        chk("clr3_restart", {16'd0, x_out, 1'b0, y_out}, 0);
        do_reset();
`else
        // without the clear engine clear_req has no effect
        do_reset();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_clear", {29'd0, grant, writeEn, clear_done}, 0);
        end
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/vga_port_arbiter.md
VGA_PORT_ARBITER -- requirements
Module: vga_port_arbiter

Interface
REQ-001 Parameter SCREEN_W, default 160: pixel columns swept by the clear engine.
REQ-002 Parameter SCREEN_H, default 120: pixel rows swept by the clear engine.
REQ-003 Parameter MAX_HOLD, default 255: maximum cycles one client grant may last.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port resetn, input, 1: reset, asynchronous and active-low.
REQ-006 Port req, input, 2: per-client request; bit i belongs to client i.
REQ-007 Port done, input, 2: per-client one-cycle end-of-burst pulse.
REQ-008 Ports c0_x/c1_x, input, 8; c0_y/c1_y, input, 7: client pixel coordinates.
REQ-009 Ports c0_colour/c1_colour, input, 3; c0_writeEn/c1_writeEn, input, 1: client pixel data and strobe.
REQ-010 Port clear_req, input, 1: one-cycle pulse requesting a full-screen black clear.
REQ-011 Port grant, output, 2: one-hot client grant, registered.
REQ-012 Ports x_out, output, 8; y_out, output, 7; colour, output, 3; writeEn, output, 1: muxed VGA adapter write port.
REQ-013 Port clear_done, output, 1: one-cycle pulse when the clear sweep finishes.
REQ-014 Port timeout, output, 1: one-cycle pulse when a grant is forcibly revoked.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT0, GRANT1 and CLEAR.
REQ-016 In IDLE, writeEn SHALL be 0, grant SHALL be 00, and x_out/y_out/colour SHALL be 0.
REQ-017 clear_req SHALL set a pending flag that holds until the CLEAR state is entered; further pulses while pending or clearing SHALL be absorbed.
REQ-018 Priority from IDLE SHALL be: pending clear first, then clients in round-robin order, where the client not served last wins on simultaneous requests.
REQ-019 A grant SHALL appear on the cycle after IDLE samples the request, giving one cycle of latency.
REQ-020 While GRANTi holds, outputs SHALL combinationally follow client i's x, y, colour and writeEn.
REQ-021 GRANTi SHALL return to IDLE on done[i], on req[i] deasserting, or when the hold counter reaches MAX_HOLD; the last case SHALL also pulse timeout.
REQ-022 Each grant SHALL be followed by at least one IDLE cycle; no back-to-back grants are allowed.
REQ-023 A clear request arriving during a grant SHALL NOT preempt that grant.
REQ-024 CLEAR SHALL sweep x fastest, from (0,0) to (SCREEN_W-1,SCREEN_H-1), at one pixel per cycle with writeEn=1 and colour=000, taking SCREEN_W*SCREEN_H cycles.
REQ-025 clear_done SHALL pulse on the cycle after the last pixel, and the FSM SHALL then return to IDLE.
REQ-026 Counters SHALL be sized to their maximum value with no wrap-around; the round-robin pointer SHALL update only when a grant is issued.

Reset
REQ-027 While resetn=0, the block SHALL be in IDLE, grant=00, all outputs 0, the clear pending flag cleared, counters 0, and the round-robin pointer set so that client 0 wins first.
REQ-028 A reset during CLEAR or GRANT SHALL abort immediately, and no clear_done or timeout pulse SHALL be issued.

Configuration
REQ-029 With VGA_ARB_CLEAR_EN defined, the clear engine SHALL be present as specified in REQ-017, REQ-024 and REQ-025.
REQ-030 Without VGA_ARB_CLEAR_EN, the CLEAR state, its counters and the pending flag SHALL be absent, clear_req SHALL be ignored, and clear_done SHALL be tied to 0.

Verification
REQ-031 req=01 held, done pulse after 30 cycles -> grant=01 one cycle after req, c0 data passed through, then one IDLE cycle with grant=00.
REQ-032 req=11 held continuously, each client pulses done after 5 cycles -> grants alternate 01,10,01 with one IDLE cycle between each.
REQ-033 req=01 held, done never pulsed, MAX_HOLD=255 -> grant revoked after 255 cycles with one timeout pulse, and client 1 is then served if requesting.
REQ-034 clear_req pulsed during GRANT0 -> GRANT0 completes, then CLEAR runs 19200 cycles with writeEn=1 and colour=000, the last pixel at (159,119), then clear_done pulses.
REQ-035 resetn pulsed low mid-CLEAR at pixel 5000 -> outputs 0 immediately, no clear_done, and the next clear restarts at (0,0).
REQ-036 Build without VGA_ARB_CLEAR_EN, pulse clear_req with req=00 -> the FSM stays in IDLE and clear_done stays 0.
